// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core101_pipe_pkg
//  Purpose  : Shared definitions for the pipeline-register sequencer.
//             Holds the FSM state encoding, the pipeline register index
//             constants and the default pipeline depth.
//  Revision : 1.0  initial release
// ============================================================================
package core101_pipe_pkg;

    // Default number of pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB)
    localparam int DEFAULT_NUM_STAGES = 4;

    // Pipeline register indices; register i feeds stage i+1
    localparam int IF_ID  = 0;
    localparam int ID_EX  = 1;
    localparam int EX_MEM = 2;
    localparam int MEM_WB = 3;

    // Sequencer FSM encoding, visible on state_out
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pipe_state_e;

endpackage : core101_pipe_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl_if
//  Purpose  : Bundle of control signals between the pipeline sequencer and
//             the datapath / pipeline registers.
//  Ports    : fetch_valid_in, stage_stall_in, flush_in, halt_in  (to ctrl)
//             set_out, bubble_out, valid_out, pc_set_out,
//             halted_out, state_out, stall_count_out             (from ctrl)
//  Modports : master - the sequencer (drives the *_out signals)
//             slave  - the datapath side (drives the *_in signals)
//  Revision : 1.0  initial release
// ============================================================================
interface pipeline_ctrl_if
    import core101_pipe_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
    parameter int CNT_WIDTH  = 16
);

    logic                  fetch_valid_in;
    logic [NUM_STAGES-1:0] stage_stall_in;
    logic                  flush_in;
    logic                  halt_in;

    logic [NUM_STAGES-1:0] set_out;
    logic [NUM_STAGES-1:0] bubble_out;
    logic [NUM_STAGES-1:0] valid_out;
    logic                  pc_set_out;
    logic                  halted_out;
    logic [1:0]            state_out;
    logic [CNT_WIDTH-1:0]  stall_count_out;

    modport master (
        input  fetch_valid_in,
        input  stage_stall_in,
        input  flush_in,
        input  halt_in,
        output set_out,
        output bubble_out,
        output valid_out,
        output pc_set_out,
        output halted_out,
        output state_out,
        output stall_count_out
    );

    modport slave (
        output fetch_valid_in,
        output stage_stall_in,
        output flush_in,
        output halt_in,
        input  set_out,
        input  bubble_out,
        input  valid_out,
        input  pc_set_out,
        input  halted_out,
        input  state_out,
        input  stall_count_out
    );

endinterface : pipeline_ctrl_if
`default_nettype wire

// File: rtl/pipeline_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that sticks at its maximum value. Cleared only by
//             the asynchronous active-low reset.
//  Ports    : clock_in   - clock, rising edge
//             reset_n_in - asynchronous active-low reset
//             inc_in     - increment request for this cycle
//             count_out  - current count
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clock_in,
    input  wire logic             reset_n_in,
    input  wire logic             inc_in,
    output logic      [WIDTH-1:0] count_out
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_count <= '0;
        end else if (inc_in && !w_at_max) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count_out = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl
//  Purpose  : Sequencer for the pipeline registers. Tracks a valid bit per
//             register, turns per-stage stalls into per-register load
//             enables, inserts bubbles, applies branch flushes and drains
//             the pipeline on a halt request.
//  Ports    : clock_in   - clock, rising edge
//             reset_n_in - asynchronous active-low reset
//             pif        - pipeline_ctrl_if.master control bundle
//  Notes    : NUM_STAGES must be at least 2;
//             1 <= FLUSH_DEPTH <= NUM_STAGES.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_ctrl
    import core101_pipe_pkg::*;
#(
    parameter int NUM_STAGES  = DEFAULT_NUM_STAGES,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  wire logic      clock_in,
    input  wire logic      reset_n_in,
    pipeline_ctrl_if.master pif
);

    // Registers killed by a flush: bits 0..FLUSH_DEPTH-1
    localparam logic [NUM_STAGES-1:0] C_FLUSH_MASK =
        ~({NUM_STAGES{1'b1}} << FLUSH_DEPTH);
    // First register past the flush boundary; it must not receive a killed
    // instruction. Empty when every register is flushable.
    localparam logic [NUM_STAGES-1:0] C_BOUNDARY =
        (FLUSH_DEPTH < NUM_STAGES) ? (NUM_STAGES'(1) << FLUSH_DEPTH) : '0;

    pipe_state_e           r_state;
    pipe_state_e           w_state_nxt;
    logic [NUM_STAGES-1:0] r_valid;

    logic [NUM_STAGES-1:0] w_ready;
    logic [NUM_STAGES-1:0] w_move;
    logic [NUM_STAGES-1:0] w_in;
    logic [NUM_STAGES-1:0] w_kill;
    logic [NUM_STAGES-1:0] w_set;
    logic [NUM_STAGES-1:0] w_bubble;
    logic [NUM_STAGES-1:0] w_valid_nxt;
    logic                  w_run;
    logic                  w_fetch;
    logic                  w_empty;
    logic                  w_stall_evt;

    // ------------------------------------------------------------------
    // Advance chain, walked from writeback backward. Writeback always
    // retires, so the register downstream of the last one is ready.
    // A running ready term keeps the chain free of combinational
    // self-reference on the vector.
    // ------------------------------------------------------------------
    always_comb begin : p_chain
        logic w_rdy;
        w_rdy   = 1'b1;
        w_move  = '0;
        w_ready = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            w_move[i]  = r_valid[i] & ~pif.stage_stall_in[i] & w_rdy;
            w_rdy      = ~r_valid[i] | w_move[i];
            w_ready[i] = w_rdy;
        end
    end

    assign w_run   = (r_state == ST_RUN);
    assign w_fetch = w_run & pif.fetch_valid_in & ~pif.flush_in;
    assign w_kill  = {NUM_STAGES{pif.flush_in}} & C_FLUSH_MASK;

    // Instruction offered to each register; a flush blocks the handoff
    // across the flush boundary so a killed instruction cannot escape.
    assign w_in = {w_move[NUM_STAGES-2:0], w_fetch}
                & ~({NUM_STAGES{pif.flush_in}} & C_BOUNDARY);

    // Flushed registers load a NOP regardless of stall or ready
    assign w_set    = w_ready | w_kill;
    assign w_bubble = w_kill | (w_ready & ~w_in);

    // Loaded registers take the incoming valid bit; flushed ones clear
    assign w_valid_nxt = (r_valid & ~w_set) | (w_set & w_in & ~w_kill);

    // A live instruction that could not be loaded past is a stall cycle
    assign w_stall_evt = |(r_valid & ~w_set);
    assign w_empty     = ~|r_valid;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Run / drain / halted sequencing. The emptiness test uses the
    // registered valid bits, so HALTED appears the cycle after the last
    // instruction leaves. Dropping halt_in always wins and returns to RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (pif.halt_in) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!pif.halt_in) begin
                    w_state_nxt = ST_RUN;
                end else if (w_empty) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (!pif.halt_in) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .inc_in     (w_stall_evt),
        .count_out  (pif.stall_count_out)
    );

    assign pif.set_out    = w_set;
    assign pif.bubble_out = w_bubble;
    assign pif.valid_out  = r_valid;
    assign pif.pc_set_out = pif.flush_in | (w_run & pif.fetch_valid_in & w_ready[0]);
    assign pif.halted_out = (r_state == ST_HALTED);
    assign pif.state_out  = r_state;

endmodule : pipeline_ctrl
`default_nettype wire
